// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RISC-V width codes, FSM state
// encoding and the funct3 legality check.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WRITE  = 2'd2,
    RESP   = 2'd3
  } lsu_state_e;

  // Stores only have signed-width codes; loads add the unsigned variants.
  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    if (we) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: extracts and extends a load value from a memory
// word, and merges byte/halfword store data into a memory word.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr,
  input  logic [31:0] word,
  input  logic [15:0] wdata,
  output logic [31:0] load_val,
  output logic [31:0] merged
);

  function automatic logic [31:0] ext8(input logic [7:0] v, input logic sgn);
    logic signed [7:0] s;
    s = v;
    return sgn ? 32'(s) : {24'd0, v};
  endfunction

  function automatic logic [31:0] ext16(input logic [15:0] v, input logic sgn);
    logic signed [15:0] s;
    s = v;
    return sgn ? 32'(s) : {16'd0, v};
  endfunction

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Halfword lane comes from addr[1] alone, so an odd halfword address
  // (when not trapped) falls back to the aligned lane below it.
  always_comb begin
    byte_sel = word[{addr, 3'b000} +: 8];
    half_sel = addr[1] ? word[31:16] : word[15:0];
    load_val = word;
    case (funct3)
      F3_B:    load_val = ext8(byte_sel, 1'b1);
      F3_BU:   load_val = ext8(byte_sel, 1'b0);
      F3_H:    load_val = ext16(half_sel, 1'b1);
      F3_HU:   load_val = ext16(half_sel, 1'b0);
      default: load_val = word;
    endcase
  end

  always_comb begin
    merged = word;
    case (funct3)
      F3_B: merged[{addr, 3'b000} +: 8] = wdata[7:0];
      F3_H: begin
        if (addr[1]) merged[31:16] = wdata;
        else         merged[15:0]  = wdata;
      end
      default: merged = word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store initiator between core and word-wide data memory.
// Optional misalignment trapping is enabled by defining LSU_MISALIGN_CHECK_EN.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter logic [31:0] ADDR_LIMIT = 32'h0004_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  lsu_state_e  state;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [1:0]  lane_q;
  logic [15:0] wdata_q;
  logic        req_err;
  logic [31:0] load_val;
  logic [31:0] merged;

  always_comb begin
    req_err = !f3_legal(req_we, req_funct3) || (req_addr >= ADDR_LIMIT);
`ifdef LSU_MISALIGN_CHECK_EN
    if ((req_funct3[1:0] == 2'b01) && req_addr[0]) req_err = 1'b1;
    if ((req_funct3 == F3_W) && (req_addr[1:0] != 2'b00)) req_err = 1'b1;
`endif
  end

  lsu_align u_align (
    .funct3   (f3_q),
    .addr     (lane_q),
    .word     (mem_rd),
    .wdata    (wdata_q),
    .load_val (load_val),
    .merged   (merged)
  );

  // Request latches carry data only and are deliberately left out of reset.
  always_ff @(posedge CLK) begin
    if (state == IDLE && req_valid) begin
      we_q    <= req_we;
      f3_q    <= req_funct3;
      lane_q  <= req_addr[1:0];
      wdata_q <= req_wdata[15:0];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= 32'd0;
      mem_we     <= 1'b0;
      mem_a      <= 32'd0;
      mem_wd     <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            if (req_err) begin
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= 32'd0;
              state      <= RESP;
            end else begin
              mem_a <= {req_addr[31:2], 2'b00};
              // A full-word store needs no read, so it writes in ACCESS.
              if (req_we && req_funct3 == F3_W) begin
                mem_we <= 1'b1;
                mem_wd <= req_wdata;
              end
              state <= ACCESS;
            end
          end
        end
        ACCESS: begin
          if (!we_q) begin
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= load_val;
            state      <= RESP;
          end else if (f3_q == F3_W) begin
            mem_we     <= 1'b0;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= 32'd0;
            state      <= RESP;
          end else begin
            mem_we <= 1'b1;
            mem_wd <= merged;
            state  <= WRITE;
          end
        end
        WRITE: begin
          mem_we     <= 1'b0;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= 32'd0;
          state      <= RESP;
        end
        RESP: begin
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          req_ready  <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: directed cases plus random traffic checked
// against a word-array reference model of memory and of the response timing.
module tb_load_store_unit;

  localparam logic [31:0] LIMIT = 32'h0004_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_we;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  logic [31:0] mem_arr [0:65535];
  logic [31:0] ref_mem [int];

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] last_rdata;
  logic [31:0] last_wd;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_LIMIT(LIMIT)) dut (
    .CLK(clk), .RST(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  assign mem_rd = mem_arr[mem_a[17:2]];
  always @(posedge clk) if (mem_we) mem_arr[mem_a[17:2]] <= mem_wd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
      else begin
        miscompares++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
  endtask

  task automatic poke(input logic [31:0] addr, input logic [31:0] val);
    mem_arr[addr[17:2]] = val;
    ref_mem[int'(addr >> 2)] = val;
  endtask

  function automatic logic [31:0] ref_word(input logic [31:0] addr);
    int idx = int'(addr >> 2);
    return ref_mem.exists(idx) ? ref_mem[idx] : 32'd0;
  endfunction

  // Expected outcome from the ISA rules: error / value / cycles to response /
  // cycle of the memory write (0 = none) / new memory word.
  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, output logic err, output logic [31:0] rdata,
                       output int lat, output int we_at, output logic [31:0] new_word);
    longint w, v, mask;
    int off, hoff, size;
    logic legal;
    w = longint'(ref_word(addr));
    size = int'(f3 & 3'b011);
    off = int'(addr % 4);
    hoff = int'((addr / 2) % 2) * 16;
    legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    err = !legal || (addr >= LIMIT);
`ifdef LSU_MISALIGN_CHECK_EN
    if (size == 1 && (addr % 2) != 0) err = 1'b1;
    if (size == 2 && (addr % 4) != 0) err = 1'b1;
`endif
    rdata = 32'd0; lat = 1; we_at = 0; new_word = 32'(w);
    if (err) return;
    if (!we) begin
      lat = 2;
      if (size == 0) begin
        v = (w >> (8 * off)) & 255;
        if (f3 == 3'd0 && v >= 128) v = v - 256;
      end else if (size == 1) begin
        v = (w >> hoff) & 65535;
        if (f3 == 3'd1 && v >= 32768) v = v - 65536;
      end else v = w;
      rdata = 32'(v);
    end else if (size == 2) begin
      lat = 2; we_at = 1; new_word = wd;
    end else begin
      lat = 3; we_at = 2;
      if (size == 0) begin
        mask = longint'(255) << (8 * off);
        v = (w & ~mask) | ((longint'(wd) & 255) << (8 * off));
      end else begin
        mask = longint'(65535) << hoff;
        v = (w & ~mask) | ((longint'(wd) & 65535) << hoff);
      end
      new_word = 32'(v & 64'hFFFF_FFFF);
    end
  endtask

  task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input string tag);
    logic e_err; logic [31:0] e_rdata, e_word;
    int e_lat, e_we_at, cyc, we_cnt, we_first;
    logic got, o_err;
    model(we, f3, addr, wd, e_err, e_rdata, e_lat, e_we_at, e_word);
    @(negedge clk);
    chk({tag, ".ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_we = $urandom_range(0, 1); req_funct3 = 3'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    cyc = 0; got = 1'b0; we_cnt = 0; we_first = 0; o_err = 1'b0;
    last_rdata = 32'd0; last_wd = 32'd0;
    while (!got && cyc < 8) begin
      @(negedge clk);
      cyc++;
      if (mem_we) begin we_cnt++; we_first = cyc; last_wd = mem_wd; end
      if (resp_valid) begin got = 1'b1; last_rdata = resp_rdata; o_err = resp_err; end
    end
    chk({tag, ".latency"}, 32'(cyc), 32'(e_lat));
    chk({tag, ".err"}, 32'(o_err), 32'(e_err));
    chk({tag, ".rdata"}, last_rdata, e_rdata);
    chk({tag, ".we_cycles"}, 32'(we_cnt), (e_we_at != 0) ? 32'd1 : 32'd0);
    chk({tag, ".we_at"}, 32'(we_first), 32'(e_we_at));
    if (e_we_at != 0) begin
      chk({tag, ".mem_wd"}, last_wd, e_word);
      ref_mem[int'(addr >> 2)] = e_word;
    end
    @(negedge clk);
    chk({tag, ".resp_pulse"}, 32'(resp_valid), 32'd0);
  endtask

  initial begin
    logic [2:0] f3;
    logic [31:0] a;
    for (int i = 0; i < 65536; i++) mem_arr[i] = 32'd0;

    // Reset state
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst.req_ready", 32'(req_ready), 32'd1);
    chk("rst.resp_valid", 32'(resp_valid), 32'd0);
    chk("rst.resp_err", 32'(resp_err), 32'd0);
    chk("rst.resp_rdata", resp_rdata, 32'd0);
    chk("rst.mem_we", 32'(mem_we), 32'd0);
    chk("rst.mem_a", mem_a, 32'd0);
    chk("rst.mem_wd", mem_wd, 32'd0);

    // Loads from a known word
    poke(32'h2000, 32'h8765_43A1);
    run_req(1'b0, 3'b000, 32'h2000, 32'd0, "lb");
    chk("lb.value", last_rdata, 32'hFFFF_FFA1);
    run_req(1'b0, 3'b100, 32'h2003, 32'd0, "lbu");
    chk("lbu.value", last_rdata, 32'h0000_0087);
    run_req(1'b0, 3'b001, 32'h2002, 32'd0, "lh");
    chk("lh.value", last_rdata, 32'hFFFF_8765);

    // Byte store read-modify-write
    poke(32'h2008, 32'h0000_000A);
    run_req(1'b1, 3'b000, 32'h2009, 32'h1234_55CC, "sb");
    chk("sb.mem_wd_value", last_wd, 32'h0000_CC0A);
    run_req(1'b0, 3'b010, 32'h2008, 32'd0, "lw_after_sb");
    chk("lw_after_sb.value", last_rdata, 32'h0000_CC0A);

    // Word store and readback
    run_req(1'b1, 3'b010, 32'h200C, 32'hDEAD_BEEF, "sw");
    run_req(1'b0, 3'b010, 32'h200C, 32'd0, "lw_after_sw");
    chk("lw_after_sw.value", last_rdata, 32'hDEAD_BEEF);

    // Errors and boundaries
    run_req(1'b0, 3'b010, LIMIT, 32'd0, "lw_limit");
    run_req(1'b1, 3'b010, LIMIT, 32'h5555_5555, "sw_limit");
    run_req(1'b0, 3'b010, LIMIT - 32'd4, 32'd0, "lw_below_limit");
    run_req(1'b0, 3'b011, 32'h2000, 32'd0, "ld_f3_011");
    run_req(1'b1, 3'b100, 32'h2000, 32'd0, "st_f3_100");
    run_req(1'b0, 3'b001, 32'h2001, 32'd0, "lh_odd");
    run_req(1'b1, 3'b001, 32'h2003, 32'h0000_7777, "sh_odd");

    // Reset during ACCESS of a byte store
    poke(32'h2010, 32'h1122_3344);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000;
    req_addr = 32'h2011; req_wdata = 32'h0000_00EE;
    @(posedge clk);
    #1 req_valid = 1'b0; rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort.mem_we", 32'(mem_we), 32'd0);
    chk("abort.resp_valid", 32'(resp_valid), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort.idle_we", 32'(mem_we), 32'd0);
      chk("abort.idle_resp", 32'(resp_valid), 32'd0);
      chk("abort.ready", 32'(req_ready), 32'd1);
    end
    chk("abort.mem_word", mem_arr[16'h0804], 32'h1122_3344);

    // Randomized traffic
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 9))
        0: f3 = 3'($urandom_range(3, 7));
        default: f3 = 3'($urandom_range(0, 5));
      endcase
      case ($urandom_range(0, 11))
        0: a = LIMIT + 32'($urandom_range(0, 255));
        1: a = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
        default: a = 32'h2000 + 32'($urandom_range(0, 63));
      endcase
      run_req(1'($urandom_range(0, 1)), f3, a, $urandom, "rand");
    end
    for (int i = 0; i < 16; i++) begin
      a = 32'h2000 + 32'(4 * i);
      run_req(1'b0, 3'b010, a, 32'd0, "rand_sweep");
      chk("rand_sweep.mem_word", mem_arr[a[17:2]], ref_word(a));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
